// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stall, flush, freeze and PC-source control, EX forwarding selects and a freeze watchdog.
// Optional performance counters are built only when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int FREEZE_MAX = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic [4:0]       ex_rs_i,
  input  logic [4:0]       ex_rt_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_wreg_i,
  input  logic             ex_jr_i,
  input  logic             mem_regwrite_i,
  input  logic [4:0]       mem_wreg_i,
  input  logic             mem_redirect_i,
  input  logic             mem_busy_i,
  input  logic             wb_regwrite_i,
  input  logic [4:0]       wb_wreg_i,
  output logic             pc_write_o,
  output logic [1:0]       pc_sel_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_flush_o,
  output logic             stage_hold_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] freeze_cnt_o
);

  typedef enum logic [1:0] {RUN, FREEZE, HALT} state_e;

  localparam int WD_W = $clog2(FREEZE_MAX + 2) + 1;

  state_e            state_q, state_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              load_use;
  logic              act;
  logic              r_redir, r_jr, r_stall;

  function automatic logic [1:0] fwd_sel(input logic [4:0] r);
    if (mem_regwrite_i && mem_wreg_i != 5'd0 && mem_wreg_i == r)
      return 2'b01;
    else if (wb_regwrite_i && wb_wreg_i != 5'd0 && wb_wreg_i == r)
      return 2'b10;
    else
      return 2'b00;
  endfunction

  assign load_use = ex_memread_i && ex_wreg_i != 5'd0 &&
                    (ex_wreg_i == id_rs_i || (id_uses_rt_i && ex_wreg_i == id_rt_i));

  // The pipe only acts on stage inputs when neither reset, halt nor a busy memory freezes it.
  assign act     = !rst_i && (state_q != HALT) && !mem_busy_i;
  assign r_redir = act && mem_redirect_i;
  assign r_jr    = act && !mem_redirect_i && ex_jr_i;
  assign r_stall = act && !mem_redirect_i && !ex_jr_i && load_use;

  assign pc_write_o     = act && !r_stall;
  assign if_id_write_o  = act && !r_stall;
  assign pc_sel_o       = r_redir ? 2'b01 : (r_jr ? 2'b10 : 2'b00);
  assign if_id_flush_o  = r_redir || r_jr;
  assign id_ex_flush_o  = r_redir || r_jr || r_stall;
  assign ex_mem_flush_o = r_redir;
  assign stage_hold_o   = !act;
  assign fwd_a_o        = rst_i ? 2'b00 : fwd_sel(ex_rs_i);
  assign fwd_b_o        = rst_i ? 2'b00 : fwd_sel(ex_rt_i);
  assign err_o          = (state_q == HALT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    case (state_q)
      RUN: begin
        if (mem_busy_i) begin
          state_d = FREEZE;
          wd_d    = WD_W'(1);
        end
      end
      FREEZE: begin
        if (!mem_busy_i) begin
          state_d = RUN;
        end else begin
          if (wd_q != '1) wd_d = wd_q + WD_W'(1);
          if (FREEZE_MAX != 0 && wd_d >= WD_W'(FREEZE_MAX)) state_d = HALT;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      if (r_stall && stall_cnt_q != '1)            stall_cnt_q  <= stall_cnt_q + CNT_W'(1);
      if ((r_redir || r_jr) && flush_cnt_q != '1)  flush_cnt_q  <= flush_cnt_q + CNT_W'(1);
      if (stage_hold_o && freeze_cnt_q != '1)      freeze_cnt_q <= freeze_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;
  assign freeze_cnt_o = freeze_cnt_q;
`else
  assign stall_cnt_o  = '0;
  assign flush_cnt_o  = '0;
  assign freeze_cnt_o = '0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central sequencer for the 5-stage pipeline CPU. It decides every cycle whether each pipeline register advances, holds or flushes, and where the PC is loaded from. It produces operand-forwarding selects for the EX stage and detects load-use hazards. It freezes the whole pipeline while the data memory is busy, with a watchdog that stops the pipe if a freeze never ends.

Parameters:
FREEZE_MAX, 64, consecutive freeze cycles before the watchdog trips; 0 disables the watchdog
CNT_W, 16, width of the saturating performance counters

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-high reset
id_rs_i  in  5  rs field of the instruction in ID
id_rt_i  in  5  rt field of the instruction in ID
id_uses_rt_i  in  1  ID instruction reads rt
ex_rs_i  in  5  rs field of the instruction in EX
ex_rt_i  in  5  rt field of the instruction in EX
ex_memread_i  in  1  EX instruction is a load
ex_wreg_i  in  5  destination register of the EX instruction
ex_jr_i  in  1  jr resolved in EX
mem_regwrite_i  in  1  MEM instruction writes the register file
mem_wreg_i  in  5  destination register of the MEM instruction
mem_redirect_i  in  1  taken branch or jump resolved in MEM
mem_busy_i  in  1  data memory not ready
wb_regwrite_i  in  1  WB instruction writes the register file
wb_wreg_i  in  5  destination register of the WB instruction
pc_write_o  out  1  PC register load enable
pc_sel_o  out  2  PC source: 00 = PC+4, 01 = MEM redirect target, 10 = jr target
if_id_write_o  out  1  IF/ID register enable
if_id_flush_o  out  1  IF/ID register loads NOP
id_ex_flush_o  out  1  ID/EX register loads bubble (controls cleared)
ex_mem_flush_o  out  1  EX/MEM register loads bubble
stage_hold_o  out  1  ID/EX, EX/MEM and MEM/WB registers hold
fwd_a_o  out  2  ALU src1 select: 00 = register file, 01 = EX/MEM, 10 = MEM/WB
fwd_b_o  out  2  ALU src2 select, same encoding as fwd_a_o
err_o  out  1  watchdog tripped (sticky)
stall_cnt_o  out  CNT_W  load-use stall cycles
flush_cnt_o  out  CNT_W  redirect events
freeze_cnt_o  out  CNT_W  freeze cycles

Behaviour:
- FSM states: RUN, FREEZE, HALT. Reset state is RUN. The FSM is registered; all control outputs are combinational from the state and inputs (zero latency).
- While rst_i is high: pc_write_o=0, if_id_write_o=0, stage_hold_o=1, all flushes 0, pc_sel_o=00, fwd selects 00, err_o=0, counters 0.
- RUN, one rule per cycle in this priority order:
  1. mem_busy_i=1: same cycle stage_hold_o=1, pc_write_o=0, if_id_write_o=0, no flushes; next state FREEZE; watchdog counter set to 1.
  2. mem_redirect_i=1: pc_sel_o=01, pc_write_o=1, and if_id_flush_o, id_ex_flush_o, ex_mem_flush_o all 1.
  3. ex_jr_i=1: pc_sel_o=10, pc_write_o=1, if_id_flush_o=1, id_ex_flush_o=1.
  4. Load-use hazard: ex_memread_i && ex_wreg_i!=0 && (ex_wreg_i==id_rs_i || (id_uses_rt_i && ex_wreg_i==id_rt_i)). Response: pc_write_o=0, if_id_write_o=0, id_ex_flush_o=1. This gives exactly one bubble because the load moves on to MEM.
  5. Otherwise: pc_write_o=1, if_id_write_o=1, pc_sel_o=00, no flush, no hold.
- FREEZE: outputs as in RUN rule 1; redirects and hazards are ignored because stage inputs are stable.
  - mem_busy_i=0: behave as RUN for that cycle (rules 2-5); next state RUN.
  - Otherwise the watchdog counter increments. When it equals FREEZE_MAX (and FREEZE_MAX!=0), next state is HALT.
- HALT: outputs held as in FREEZE, err_o=1. Exit only by reset.
- Forwarding, evaluated for src1 using ex_rs_i and for src2 using ex_rt_i:
  - 01 if mem_regwrite_i && mem_wreg_i!=0 && mem_wreg_i==reg.
  - Else 10 if wb_regwrite_i && wb_wreg_i!=0 && wb_wreg_i==reg.
  - Else 00.
  - EX/MEM has priority over MEM/WB. Register 0 never forwards.
- Simultaneous mem_redirect_i and ex_jr_i: the MEM redirect wins, since it is the older instruction.

Optional Feature:
HAZ_PERF_CNT_EN.
- Defined: the counters saturate at all ones and clear on reset.
  - stall_cnt_o increments on every rule-4 cycle.
  - flush_cnt_o increments on every rule-2 or rule-3 cycle.
  - freeze_cnt_o increments on every cycle with stage_hold_o=1 outside reset.
- Undefined: the counter logic is removed and all three ports are tied to 0.

Test Plan:
- Reset held high, then released → first clock in RUN: pc_write_o=1, if_id_write_o=1, fwd 00, err_o=0.
- lw $2 in EX (ex_memread_i=1, ex_wreg_i=2), ID instruction with id_rs_i=2 → one cycle of pc_write_o=0, if_id_write_o=0, id_ex_flush_o=1; next cycle normal; stall_cnt_o=1.
- mem_regwrite_i=1, mem_wreg_i=5, wb_regwrite_i=1, wb_wreg_i=5, ex_rs_i=5, ex_rt_i=0 → fwd_a_o=01, fwd_b_o=00. Repeat with mem_regwrite_i=0 → fwd_a_o=10.
- mem_redirect_i=1 and ex_jr_i=1 together → pc_sel_o=01, all three flushes 1; flush_cnt_o +1.
- mem_busy_i high for 3 cycles (FREEZE_MAX=64) → stage_hold_o=1 and pc_write_o=0 for 3 cycles, release on the 4th; freeze_cnt_o=3; err_o stays 0.
- FREEZE_MAX=4, mem_busy_i held high → HALT after 4 freeze cycles, err_o=1, stays 1 after mem_busy_i drops; rst_i pulse clears it.
